// File: rtl/byte_block_loader_if.sv
// Byte-load side and block-presentation side of the turbo-coder block loader.
// master: upstream byte source plus block consumer; slave: the loader itself.
interface byte_block_loader_if #(
  parameter int K_LARGE = 6144,
  parameter int CNT_W   = 10
);
  logic               k_size_6144;
  logic [7:0]         databit_in;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic               out_ack;
  logic [K_LARGE-1:0] block_data;
  logic               block_valid;
  logic               block_k_6144;
  logic [CNT_W-1:0]   byte_count;

  modport master (
    output k_size_6144, databit_in, in_valid, flush, out_ack,
    input  in_ready, block_data, block_valid, block_k_6144, byte_count
  );

  modport slave (
    input  k_size_6144, databit_in, in_valid, flush, out_ack,
    output in_ready, block_data, block_valid, block_k_6144, byte_count
  );
endinterface

// File: rtl/byte_block_loader.sv
// Packs a byte stream into one 1056- or 6144-bit code block, then holds it
// stable for the interleaver until the consumer acknowledges it.
module byte_block_loader #(
  parameter int K_SMALL = 1056,
  parameter int K_LARGE = 6144,
  parameter int CNT_W   = 10
) (
  input  logic              clock,
  input  logic              reset,
  byte_block_loader_if.slave bus
);

  localparam int IDX_W = $clog2(K_LARGE);
  localparam logic [CNT_W-1:0] N_SMALL = CNT_W'(K_SMALL / 8);
  localparam logic [CNT_W-1:0] N_LARGE = CNT_W'(K_LARGE / 8);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL
  } state_t;

  state_t             state, state_next;
  logic [K_LARGE-1:0] data_q;
  logic               k_q;
  logic [CNT_W-1:0]   count_q;
  logic               valid_q;
  logic               ready_q;

  logic               accept;
  logic               take_first;
  logic               take_byte;
  logic               do_flush;
  logic               do_ack;
  logic [CNT_W-1:0]   count_inc;
  logic [CNT_W-1:0]   target;
  logic [IDX_W-1:0]   wr_bit;

  assign bus.block_data   = data_q;
  assign bus.block_k_6144 = k_q;
  assign bus.byte_count   = count_q;
  assign bus.block_valid  = valid_q;
  assign bus.in_ready     = ready_q;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and datapath strobes; flush outranks ack and transfer
  always_comb begin
    state_next = state;
    take_first = 1'b0;
    take_byte  = 1'b0;
    do_flush   = 1'b0;
    do_ack     = 1'b0;
    accept     = bus.in_valid && ready_q;
    count_inc  = count_q + 1'b1;
    target     = k_q ? N_LARGE : N_SMALL;
    wr_bit     = IDX_W'({count_q, 3'b000});
    if (bus.flush) begin
      do_flush   = 1'b1;
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            take_first = 1'b1;
            state_next = FILL;
          end
        end
        FILL: begin
          if (accept) begin
            take_byte = 1'b1;
            if (count_inc == target) state_next = FULL;
          end
        end
        FULL: begin
          if (bus.out_ack) begin
            do_ack     = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Block buffer, size latch, byte counter and registered handshake flags
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      k_q     <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      // in_ready and block_valid follow the state being entered, so they
      // change on the same edge as the state itself
      ready_q <= (state_next != FULL);
      valid_q <= (state_next == FULL);
      if (do_flush) begin
        data_q  <= '0;
        count_q <= '0;
      end else if (take_first) begin
        k_q     <= bus.k_size_6144;
        data_q  <= {{(K_LARGE-8){1'b0}}, bus.databit_in};
        count_q <= CNT_W'(1);
      end else if (take_byte) begin
        data_q[wr_bit +: 8] <= bus.databit_in;
        count_q             <= count_inc;
      end else if (do_ack) begin
        count_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_byte_block_loader.sv
// Self-checking bench for byte_block_loader: a byte-level model queues each
// expected finished block, which is popped and compared when block_valid rises.
module tb_byte_block_loader;

  localparam int KS = 1056;
  localparam int KL = 6144;
  localparam int CW = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  byte_block_loader_if #(.K_LARGE(KL), .CNT_W(CW)) bus();

  byte_block_loader #(.K_SMALL(KS), .K_LARGE(KL), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [KL-1:0] data;
    logic          k;
    logic [CW-1:0] cnt;
  } blk_t;

  blk_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  logic [KL-1:0] m_data;
  logic          m_k;
  int            m_count = 0;

  // Reference model of one accepted byte; pushes the finished block
  function automatic void model_accept(input logic [7:0] b, input logic k);
    blk_t e;
    if (m_count == 0) begin
      m_k    = k;
      m_data = '0;
    end
    m_data[m_count*8 +: 8] = b;
    m_count++;
    if (m_count == (m_k ? KL/8 : KS/8)) begin
      e.data = m_data;
      e.k    = m_k;
      e.cnt  = CW'(m_count);
      sb.push_back(e);
    end
  endfunction

  function automatic int first_diff(input logic [KL-1:0] a, input logic [KL-1:0] b);
    for (int i = 0; i < KL/8; i++)
      if (a[i*8 +: 8] !== b[i*8 +: 8]) return i;
    return -1;
  endfunction

  // Offer one byte for one cycle; acc tells whether the edge took it
  task automatic offer(input logic [7:0] b, input logic k, output bit acc);
    @(negedge clock);
    bus.databit_in  = b;
    bus.k_size_6144 = k;
    bus.in_valid    = 1'b1;
    acc = (bus.in_ready === 1'b1);
    @(posedge clock);
    if (acc) model_accept(b, k);
  endtask

  task automatic gap();
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(posedge clock);
  endtask

  task automatic ack_block();
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.out_ack  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ack = 1'b0;
    m_count = 0;
  endtask

  // Bounded wait for block_valid; lat = negedges waited after the call
  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clock);
    while (bus.block_valid !== 1'b1 && lat < 8) begin
      lat++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    bus.in_valid    = 1'b1;
    bus.databit_in  = 8'h11;
    bus.k_size_6144 = 1'b1;
    bus.flush       = 1'b0;
    bus.out_ack     = 1'b0;
    reset           = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks += 5;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
    if (bus.block_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.block_valid); end
    if (bus.block_data !== '0) begin errors++; $display("FAIL rst_data low got %h exp 0", bus.block_data[63:0]); end
    if (bus.block_k_6144 !== 1'b0) begin errors++; $display("FAIL rst_k got %b exp 0", bus.block_k_6144); end
    if (bus.byte_count !== '0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.byte_count); end
    reset = 1'b0;
    @(negedge clock);
    checks += 2;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", bus.in_ready); end
    if (bus.byte_count !== '0) begin errors++; $display("FAIL rst_no_accept count got %0d exp 0", bus.byte_count); end
    bus.in_valid = 1'b0;
    m_count = 0;
  endtask

  task automatic test_small_back_to_back();
    bit   acc;
    int   miss = 0;
    int   lat;
    int   d;
    blk_t e;
    for (int i = 0; i < KS/8; i++) begin
      offer(8'(i), 1'b0, acc);
      if (!acc) miss++;
      if (i == KS/8 - 2) begin
        #1;
        checks++;
        if (bus.block_valid !== 1'b0) begin errors++; $display("FAIL small_early_valid got %b exp 0", bus.block_valid); end
      end
    end
    checks++;
    if (miss != 0) begin errors++; $display("FAIL small_accepts refused=%0d exp 0", miss); end
    wait_valid(lat);
    checks++;
    if (lat != 0) begin errors++; $display("FAIL small_latency waited=%0d exp 0", lat); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL small_sb no expected block queued"); end
    else begin
      e = sb.pop_front();
      d = first_diff(bus.block_data, e.data);
      checks += 3;
      if (d != -1) begin errors++; $display("FAIL small_data byte %0d got %02h exp %02h", d, bus.block_data[d*8 +: 8], e.data[d*8 +: 8]); end
      if (bus.block_k_6144 !== e.k) begin errors++; $display("FAIL small_k got %b exp %b", bus.block_k_6144, e.k); end
      if (bus.byte_count !== e.cnt) begin errors++; $display("FAIL small_count got %0d exp %0d", bus.byte_count, e.cnt); end
    end
    checks += 4;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL small_in_ready got %b exp 0", bus.in_ready); end
    if (bus.block_data[7:0] !== 8'h00) begin errors++; $display("FAIL small_byte0 got %02h exp 00", bus.block_data[7:0]); end
    if (bus.block_data[1055:1048] !== 8'h83) begin errors++; $display("FAIL small_byte131 got %02h exp 83", bus.block_data[1055:1048]); end
    if (bus.block_data[KL-1:KS] !== '0) begin errors++; $display("FAIL small_upper_zero got nonzero above bit %0d", KS); end
    ack_block();
  endtask

  task automatic test_large_gaps();
    bit   acc;
    int   miss = 0;
    int   lat;
    int   d;
    blk_t e;
    for (int i = 0; i < KL/8; i++) begin
      if ($urandom_range(0, 3) == 0) gap();
      offer(8'(i), 1'b1, acc);
      if (!acc) miss++;
      if (i == KL/8 - 2) begin
        #1;
        checks++;
        if (bus.block_valid !== 1'b0) begin errors++; $display("FAIL large_early_valid got %b exp 0", bus.block_valid); end
      end
    end
    checks++;
    if (miss != 0) begin errors++; $display("FAIL large_accepts refused=%0d exp 0", miss); end
    wait_valid(lat);
    checks++;
    if (lat != 0) begin errors++; $display("FAIL large_latency waited=%0d exp 0", lat); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL large_sb no expected block queued"); end
    else begin
      e = sb.pop_front();
      d = first_diff(bus.block_data, e.data);
      checks += 3;
      if (d != -1) begin errors++; $display("FAIL large_data byte %0d got %02h exp %02h", d, bus.block_data[d*8 +: 8], e.data[d*8 +: 8]); end
      if (bus.block_k_6144 !== e.k) begin errors++; $display("FAIL large_k got %b exp %b", bus.block_k_6144, e.k); end
      if (bus.byte_count !== e.cnt) begin errors++; $display("FAIL large_count got %0d exp %0d", bus.byte_count, e.cnt); end
    end
    checks += 2;
    if (bus.block_data[6143:6136] !== 8'hFF) begin errors++; $display("FAIL large_last_byte got %02h exp ff", bus.block_data[6143:6136]); end
    if (bus.block_k_6144 !== 1'b1) begin errors++; $display("FAIL large_k_abs got %b exp 1", bus.block_k_6144); end
  endtask

  task automatic test_hold_and_ack();
    bit            acc;
    int            taken = 0;
    logic [KL-1:0] snap;
    snap = bus.block_data;
    for (int i = 0; i < 10; i++) begin
      offer(8'hAA, 1'b0, acc);
      if (acc) taken++;
    end
    @(negedge clock);
    checks += 4;
    if (taken != 0) begin errors++; $display("FAIL hold_accepts got %0d exp 0", taken); end
    if (bus.block_data !== snap) begin errors++; $display("FAIL hold_data changed at byte %0d", first_diff(bus.block_data, snap)); end
    if (bus.byte_count !== CW'(KL/8)) begin errors++; $display("FAIL hold_count got %0d exp %0d", bus.byte_count, KL/8); end
    if (bus.block_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b exp 1", bus.block_valid); end
    bus.in_valid = 1'b0;
    bus.out_ack  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ack = 1'b0;
    m_count = 0;
    checks += 4;
    if (bus.block_valid !== 1'b0) begin errors++; $display("FAIL ack_valid got %b exp 0", bus.block_valid); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ack_in_ready got %b exp 1", bus.in_ready); end
    if (bus.byte_count !== '0) begin errors++; $display("FAIL ack_count got %0d exp 0", bus.byte_count); end
    if (bus.block_data !== snap) begin errors++; $display("FAIL ack_data_kept changed at byte %0d", first_diff(bus.block_data, snap)); end
    offer(8'h5C, 1'b0, acc);
    @(negedge clock);
    checks += 4;
    if (!acc) begin errors++; $display("FAIL next_accept got refused exp accepted"); end
    if (bus.block_data[7:0] !== 8'h5C) begin errors++; $display("FAIL next_byte0 got %02h exp 5c", bus.block_data[7:0]); end
    if (bus.block_data[KL-1:8] !== '0) begin errors++; $display("FAIL next_upper_cleared got nonzero above bit 8"); end
    if (bus.byte_count !== CW'(1)) begin errors++; $display("FAIL next_count got %0d exp 1", bus.byte_count); end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.flush = 1'b0;
    m_count = 0;
  endtask

  task automatic test_k_toggle();
    bit   acc;
    int   lat;
    int   d;
    blk_t e;
    for (int i = 0; i < KS/8; i++) offer(8'(i*7 + 3), (i >= 5), acc);
    wait_valid(lat);
    checks++;
    if (lat != 0) begin errors++; $display("FAIL ktog_latency waited=%0d exp 0", lat); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL ktog_sb no expected block queued"); end
    else begin
      e = sb.pop_front();
      d = first_diff(bus.block_data, e.data);
      checks += 2;
      if (d != -1) begin errors++; $display("FAIL ktog_data byte %0d got %02h exp %02h", d, bus.block_data[d*8 +: 8], e.data[d*8 +: 8]); end
      if (bus.byte_count !== e.cnt) begin errors++; $display("FAIL ktog_count got %0d exp %0d", bus.byte_count, e.cnt); end
    end
    checks++;
    if (bus.block_k_6144 !== 1'b0) begin errors++; $display("FAIL ktog_k got %b exp 0", bus.block_k_6144); end
    ack_block();
  endtask

  task automatic test_flush();
    bit   acc;
    int   lat;
    int   d;
    blk_t e;
    for (int i = 0; i < 50; i++) offer(8'(i) ^ 8'h5A, 1'b0, acc);
    @(negedge clock);
    bus.flush      = 1'b1;
    bus.in_valid   = 1'b1;
    bus.databit_in = 8'hEE;
    @(posedge clock);
    @(negedge clock);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    m_count = 0;
    checks += 4;
    if (bus.byte_count !== '0) begin errors++; $display("FAIL flush_count got %0d exp 0", bus.byte_count); end
    if (bus.block_data !== '0) begin errors++; $display("FAIL flush_data got nonzero, low %h exp 0", bus.block_data[63:0]); end
    if (bus.block_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", bus.block_valid); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", bus.in_ready); end
    for (int i = 0; i < KS/8; i++) offer(8'(255 - i), 1'b0, acc);
    wait_valid(lat);
    checks++;
    if (lat != 0) begin errors++; $display("FAIL flush_new_latency waited=%0d exp 0", lat); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL flush_sb no expected block queued"); end
    else begin
      e = sb.pop_front();
      d = first_diff(bus.block_data, e.data);
      checks += 3;
      if (d != -1) begin errors++; $display("FAIL flush_new_data byte %0d got %02h exp %02h", d, bus.block_data[d*8 +: 8], e.data[d*8 +: 8]); end
      if (bus.block_k_6144 !== e.k) begin errors++; $display("FAIL flush_new_k got %b exp %b", bus.block_k_6144, e.k); end
      if (bus.byte_count !== e.cnt) begin errors++; $display("FAIL flush_new_count got %0d exp %0d", bus.byte_count, e.cnt); end
    end
    ack_block();
  endtask

  task automatic test_reset_mid_block();
    bit   acc;
    int   lat;
    int   d;
    blk_t e;
    for (int i = 0; i < 300; i++) offer(8'(i + 1), 1'b1, acc);
    @(negedge clock);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks += 5;
    if (bus.byte_count !== '0) begin errors++; $display("FAIL mrst_count got %0d exp 0", bus.byte_count); end
    if (bus.block_data !== '0) begin errors++; $display("FAIL mrst_data got nonzero, low %h exp 0", bus.block_data[63:0]); end
    if (bus.block_k_6144 !== 1'b0) begin errors++; $display("FAIL mrst_k got %b exp 0", bus.block_k_6144); end
    if (bus.block_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b exp 0", bus.block_valid); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mrst_in_ready got %b exp 0", bus.in_ready); end
    reset = 1'b0;
    m_count = 0;
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready_after got %b exp 1", bus.in_ready); end
    for (int i = 0; i < KL/8; i++) offer(8'(i * 13), 1'b1, acc);
    wait_valid(lat);
    checks++;
    if (lat != 0) begin errors++; $display("FAIL mrst_new_latency waited=%0d exp 0", lat); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL mrst_sb no expected block queued"); end
    else begin
      e = sb.pop_front();
      d = first_diff(bus.block_data, e.data);
      checks += 3;
      if (d != -1) begin errors++; $display("FAIL mrst_new_data byte %0d got %02h exp %02h", d, bus.block_data[d*8 +: 8], e.data[d*8 +: 8]); end
      if (bus.block_k_6144 !== e.k) begin errors++; $display("FAIL mrst_new_k got %b exp %b", bus.block_k_6144, e.k); end
      if (bus.byte_count !== e.cnt) begin errors++; $display("FAIL mrst_new_count got %0d exp %0d", bus.byte_count, e.cnt); end
    end
    ack_block();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_small_back_to_back();
    test_large_gaps();
    test_hold_and_ack();
    test_k_toggle();
    test_flush();
    test_reset_mid_block();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
